serial_adder: RTL and testbench
===============================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one full_adder_1bit instance, which is the combinational stage this block drives.
- Operands are accepted through a valid/ready handshake and summed LSB first, one bit per clock, with a registered carry.
- The result is held on a valid/ready output until consumed.
- Sits between the operand source (register file / switches) and the display/result logic in the lab datapath.

Parameters:
- WIDTH, 4, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  system clock, rising-edge active
- rst_n  input  1  asynchronous active-low reset
- start_valid  input  1  operands a, b, cin present
- start_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in for bit 0
- result_valid  output  1  sum/cout valid
- result_ready  input  1  consumer takes result
- sum  output  WIDTH  registered sum
- cout  output  1  registered carry-out of MSB
- busy  output  1  high while bits are being added

Behaviour:
- Interface: one clock; reset is asynchronous and active-low (clk, rst_n).
- Reset (rst_n=0, any time including mid-operation):
  - state=IDLE; shift registers, carry register and bit counter cleared.
  - sum=0, cout=0, result_valid=0, busy=0, start_ready=1.
  - An operation in flight is discarded.
- FSM states: IDLE, ADD, DONE.
- IDLE:
  - start_ready=1.
  - On start_valid && start_ready at a rising edge, latch a and b into shift regs A_sh and B_sh, load carry reg with cin, clear counter, go to ADD.
  - Inputs are sampled only at acceptance; later changes are ignored.
- ADD:
  - busy=1, start_ready=0.
  - The full_adder_1bit inputs are A_sh[0], B_sh[0] and carry reg.
  - At each edge: A_sh and B_sh shift right; the adder's sum bit shifts into the MSB of the result shift reg (shift right); carry reg takes the adder's cout; counter increments.
  - After the WIDTH-th ADD edge, go to DONE. The counter is $clog2(WIDTH+1) bits and never wraps during an operation.
- DONE:
  - result_valid=1, busy=0, start_ready=0.
  - sum = result shift reg and cout = carry reg, both held stable while result_ready=0.
  - On result_ready=1 at an edge, clear result_valid and go to IDLE.
  - There is no same-cycle restart; the earliest next acceptance is one cycle after the result is taken.
- Latency: acceptance edge E0; result_valid rises after edge E_WIDTH, i.e. WIDTH cycles later. Throughput is one operation per WIDTH+2 cycles minimum.
- Arithmetic: {cout,sum} = a + b + cin, modulo 2^(WIDTH+1). Overflow is not flagged separately.
- Boundary conditions:
  - start_valid asserted while in ADD or DONE is ignored (start_ready=0); the source must hold it.
  - result_ready held high continuously is legal; DONE then lasts exactly one cycle.
  - sum/cout are retained after the handshake until the next DONE overwrites them.

Optional Feature:
- Macro SERIAL_ADDER_SUB_EN.
- When defined:
  - Adds input port sub (1 bit), latched at acceptance with the operands.
  - sub=1 loads ~b into B_sh and forces carry reg to 1, ignoring cin, so sum = a - b mod 2^WIDTH.
  - cout=1 means no borrow.
  - sub=0 behaves exactly as base.
- When undefined: no sub port; add-only behaviour as above.

Test Plan:
- WIDTH=4. Send a=0011, b=0101, cin=0 with result_ready=1 -> result_valid high exactly 4 cycles after acceptance, sum=1000, cout=0, busy high for those 4 cycles.
- Send a=1111, b=0001, cin=0, then a=1111, b=1111, cin=1 -> sum=0000, cout=1, then sum=1111, cout=1.
- Backpressure: after a=0110, b=0011, cin=0, hold result_ready=0 for 3 cycles while pulsing start_valid with new operands -> sum=1001, cout=0 stable, start_ready=0, new operands not accepted. Raise result_ready -> IDLE, then the new operands are accepted.
- Reset mid-op: deassert rst_n asynchronously after 2 ADD cycles -> sum=0, cout=0, result_valid=0, busy=0, start_ready=1 immediately. After release, a=0001, b=0001, cin=1 -> sum=0011, cout=0.
- Exhaustive sweep: all 512 (a,b,cin) combinations against the reference model a+b+cin -> zero mismatches.
- SERIAL_ADDER_SUB_EN defined: sub=1, a=0101, b=0011 -> sum=0010, cout=1; sub=1, a=0011, b=0101 -> sum=1110, cout=0.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand/result handshake bundle for serial_adder; the sub field exists only
// when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int WIDTH = 4
);
  // Both channels use valid/ready: a transfer happens on a rising edge where
  // valid && ready. The producer holds valid and its payload until that edge,
  // and ready never depends combinationally on valid.
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             result_valid;
  logic             result_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport slave (
`ifdef SERIAL_ADDER_SUB_EN
    input  sub,
`endif
    input  start_valid, a, b, cin, result_ready,
    output start_ready, result_valid, sum, cout, busy
  );

  modport master (
`ifdef SERIAL_ADDER_SUB_EN
    output sub,
`endif
    output start_valid, a, b, cin, result_ready,
    input  start_ready, result_valid, sum, cout, busy
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder, LSB first, one bit per clock through a single full adder.
// Define SERIAL_ADDER_SUB_EN to add a latched subtract mode (a - b, cout=1 means no borrow).
module full_adder_1bit (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i ^ c_i;
  assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_adder #(
  parameter int WIDTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  serial_adder_if.slave     bus,
  output logic [1:0]        dbg_state_o
);
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             result_valid_q;
  logic             busy_q;
  logic             start_ready_q;

  logic             fa_s;
  logic             fa_c;
  logic [WIDTH-1:0] res_d;
  logic [WIDTH-1:0] b_load_d;
  logic             carry_load_d;

  full_adder_1bit u_fa (
    .a_i (a_sh_q[0]),
    .b_i (b_sh_q[0]),
    .c_i (carry_q),
    .s_o (fa_s),
    .c_o (fa_c)
  );

  // Subtraction is a + ~b + 1, so only the B load and the initial carry change.
  always_comb begin
    b_load_d     = bus.b;
    carry_load_d = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_load_d     = ~bus.b;
      carry_load_d = 1'b1;
    end
`endif
  end

  always_comb begin
    res_d            = res_sh_q >> 1;
    res_d[WIDTH-1]   = fa_s;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      a_sh_q         <= '0;
      b_sh_q         <= '0;
      res_sh_q       <= '0;
      carry_q        <= 1'b0;
      cnt_q          <= '0;
      sum_q          <= '0;
      cout_q         <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
      start_ready_q  <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start_valid) begin
            a_sh_q        <= bus.a;
            b_sh_q        <= b_load_d;
            carry_q       <= carry_load_d;
            cnt_q         <= '0;
            busy_q        <= 1'b1;
            start_ready_q <= 1'b0;
            state_q       <= ADD;
          end
        end
        ADD: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_d;
          carry_q  <= fa_c;
          cnt_q    <= cnt_q + CW'(1);
          // Output regs are loaded only here so they survive the next operation.
          if (cnt_q == CW'(WIDTH - 1)) begin
            sum_q          <= res_d;
            cout_q         <= fa_c;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b1;
            state_q        <= DONE;
          end
        end
        DONE: begin
          if (bus.result_ready) begin
            result_valid_q <= 1'b0;
            start_ready_q  <= 1'b1;
            state_q        <= IDLE;
          end
        end
        default: begin
          result_valid_q <= 1'b0;
          busy_q         <= 1'b0;
          start_ready_q  <= 1'b1;
          state_q        <= IDLE;
        end
      endcase
    end
  end

  assign bus.start_ready  = start_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.sum          = sum_q;
  assign bus.cout         = cout_q;
  assign bus.busy         = busy_q;
  assign dbg_state_o      = state_q;
endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder (WIDTH=4): latency, backpressure, async reset,
// exhaustive add sweep, and subtract vectors when SERIAL_ADDER_SUB_EN is defined.
`timescale 1ns/1ps
module tb_serial_adder;
  localparam int W = 4;

  logic       clk;
  logic       rst_n;
  logic [1:0] dbg_state;
  int         n_checks;
  int         n_pass;
  logic [W:0] exp_q[$];

  serial_adder_if #(.WIDTH(W)) bus ();

  serial_adder #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus.slave),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp)
      $display("FAIL %s: got %0h, required %0h", tag, obs, exp);
    else
      n_pass++;
  endtask

  // driver: present operands and hold until the accepting edge
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
    int n;
    @(negedge clk);
    bus.a           = a;
    bus.b           = b;
    bus.cin         = cin;
    bus.start_valid = 1'b1;
    n = 0;
    while (!bus.start_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("start_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
  endtask

  task automatic wait_result();
    int n;
    n = 0;
    while (!bus.result_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("result_timeout", 32'd0, 32'd1);
  endtask

  // scoreboard: pop the expected {cout,sum} when the result shows up
  task automatic collect(input string tag);
    logic [W:0] exp;
    wait_result();
    exp = exp_q.pop_front();
    check(tag, {27'd0, bus.cout, bus.sum}, {27'd0, exp});
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic [W:0] exp);
    exp_q.push_back(exp);
    send(a, b, cin);
    collect(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks         = 0;
    n_pass           = 0;
    rst_n            = 1'b0;
    bus.start_valid  = 1'b0;
    bus.a            = '0;
    bus.b            = '0;
    bus.cin          = 1'b0;
    bus.result_ready = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    bus.sub          = 1'b0;
`endif
    #12;
    check("rst_start_ready", bus.start_ready, 1);
    check("rst_result_valid", bus.result_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    check("rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // latency and busy window: 3 + 5 + 0 = 8
    bus.result_ready = 1'b1;
    send(4'b0011, 4'b0101, 1'b0);
    for (int k = 0; k < W; k++) begin
      @(negedge clk);
      check("lat_busy", bus.busy, 1);
      check("lat_not_valid", bus.result_valid, 0);
    end
    @(negedge clk);
    check("lat_valid", bus.result_valid, 1);
    check("lat_busy_low", bus.busy, 0);
    check("lat_sum", bus.sum, 4'b1000);
    check("lat_cout", bus.cout, 0);
    @(negedge clk);
    check("lat_consumed", bus.result_valid, 0);
    check("lat_ready_again", bus.start_ready, 1);
    @(posedge clk);
    #1;

    run_op("f_plus_1", 4'b1111, 4'b0001, 1'b0, 5'b1_0000);
    run_op("f_plus_f_c", 4'b1111, 4'b1111, 1'b1, 5'b1_1111);

    // backpressure: 6 + 3 = 9 held while new operands are offered
    bus.result_ready = 1'b0;
    exp_q.push_back(5'b0_1001);
    send(4'b0110, 4'b0011, 1'b0);
    wait_result();
    bus.a           = 4'b0001;
    bus.b           = 4'b0010;
    bus.cin         = 1'b0;
    bus.start_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      check("bp_valid", bus.result_valid, 1);
      check("bp_sum", bus.sum, 4'b1001);
      check("bp_cout", bus.cout, 0);
      check("bp_start_ready", bus.start_ready, 0);
      check("bp_state", dbg_state, 2);
      @(negedge clk);
    end
    void'(exp_q.pop_front());
    bus.result_ready = 1'b1;
    exp_q.push_back(5'b0_0011);
    @(negedge clk);
    check("bp_idle_ready", bus.start_ready, 1);
    check("bp_idle_valid", bus.result_valid, 0);
    check("bp_sum_retained", bus.sum, 4'b1001);
    @(posedge clk);
    #1;
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("bp_new_accepted", bus.busy, 1);
    collect("bp_new_result");
    @(posedge clk);
    #1;

    // asynchronous reset after two ADD edges
    send(4'b1010, 4'b0101, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("mid_rst_sum", bus.sum, 0);
    check("mid_rst_cout", bus.cout, 0);
    check("mid_rst_valid", bus.result_valid, 0);
    check("mid_rst_busy", bus.busy, 0);
    check("mid_rst_ready", bus.start_ready, 1);
    check("mid_rst_state", dbg_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op("after_rst", 4'b0001, 4'b0001, 1'b1, 5'b0_0011);

    // exhaustive sweep against a + b + cin
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        for (int c = 0; c < 2; c++)
          run_op("sweep", 4'(a), 4'(b), 1'(c), 5'(a + b + c));

`ifdef SERIAL_ADDER_SUB_EN
    bus.sub = 1'b1;
    run_op("sub_5_3", 4'b0101, 4'b0011, 1'b0, 5'b1_0010);
    run_op("sub_3_5", 4'b0011, 4'b0101, 1'b0, 5'b0_1110);
    bus.sub = 1'b0;
    run_op("sub_off", 4'b0011, 4'b0101, 1'b1, 5'b0_1001);
`endif

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
